// File: rtl/async_receiver_pkg.sv
// Shared UART constants: default clocking, frame shape for both directions,
// receiver FSM encoding and a small majority-vote helper.
package async_receiver_pkg;

  localparam int unsigned UART_CLK_FREQ  = 25000000;
  localparam int unsigned UART_BAUD      = 115200;
  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/async_receiver_if.sv
// Serial line plus received-byte status bundle; the receiver is the master.
interface async_receiver_if;
  import async_receiver_pkg::*;

  logic                      RxD;
  logic [UART_DATA_BITS-1:0] RxD_data;
  logic                      RxD_data_ready;
  logic                      RxD_frame_error;
  logic                      RxD_idle;
  logic                      RxD_endofpacket;

  modport master (
    input  RxD,
    output RxD_data, RxD_data_ready, RxD_frame_error, RxD_idle, RxD_endofpacket
  );

  modport slave (
    output RxD,
    input  RxD_data, RxD_data_ready, RxD_frame_error, RxD_idle, RxD_endofpacket
  );
endinterface

// File: rtl/async_receiver_baudrate_gen.sv
// Fractional accumulator tick generator: one-clk tick at Baud Hz on average.
module baudrate_gen #(
  parameter int unsigned ClkFrequency = 25000000,
  parameter int unsigned Baud         = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  logic [31:0] acc_q, acc_d;
  logic        tick_q, tick_d;
  logic [32:0] sum_s;

  // accumulate Baud per clk and wrap at ClkFrequency
  always_comb begin
    sum_s  = {1'b0, acc_q} + 33'(Baud);
    acc_d  = acc_q;
    tick_d = 1'b0;
    if (!enable) begin
      acc_d  = acc_q;
      tick_d = 1'b0;
    end else if (sum_s >= 33'(ClkFrequency)) begin
      acc_d  = 32'(sum_s - 33'(ClkFrequency));
      tick_d = 1'b1;
    end else begin
      acc_d  = sum_s[31:0];
      tick_d = 1'b0;
    end
  end

  // accumulator and tick registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= 32'd0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/async_receiver.sv
// 8N1 UART receiver: synchronizer, 2-of-3 oversampled filter, framing FSM,
// and idle-gap / end-of-packet detection.
module async_receiver
  import async_receiver_pkg::*;
#(
  parameter int unsigned ClkFrequency = UART_CLK_FREQ,
  parameter int unsigned Baud         = UART_BAUD,
  parameter int unsigned Oversampling = 8
) (
  input logic              clk,
  input logic              rst_n,
  async_receiver_if.master rx
);

  if (ClkFrequency < Baud * Oversampling) begin : g_rate_check
    $error("async_receiver: ClkFrequency below Baud*Oversampling");
  end
  if ((Oversampling < 4) || ((Oversampling & (Oversampling - 1)) != 0)) begin : g_ovs_check
    $error("async_receiver: Oversampling must be a power of two >= 4");
  end

  localparam int unsigned PhaseW = $clog2(Oversampling);
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(Oversampling - 1);
  localparam logic [PhaseW-1:0] PhaseHalf = PhaseW'(Oversampling / 2 - 1);
  localparam int unsigned GapMax = 16 * Oversampling;
  localparam int unsigned GapW   = $clog2(GapMax + 1);

  logic        tick_s;
  logic [1:0]  sync_q;
  logic [1:0]  hist_q;
  logic        filt_q;

  rx_state_e   state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        ferr_q, ferr_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic        idle_q, idle_d;
  logic        eop_q, eop_d;
  logic        got_byte_q, got_byte_d;

  baudrate_gen #(
    .ClkFrequency(ClkFrequency),
    .Baud        (Baud * Oversampling)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(1'b1),
    .tick  (tick_s)
  );

  // line synchronizer and tick-sampled majority filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      hist_q <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx.RxD};
      if (tick_s) begin
        hist_q <= {hist_q[0], sync_q[1]};
        filt_q <= majority3({hist_q, sync_q[1]});
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; every decision is taken on a tick
  always_comb begin
    state_d = state_q;
    if (tick_s) begin
      case (state_q)
        IDLE: begin
          if (!filt_q) state_d = START;
          else         state_d = IDLE;
        end
        START: begin
          if (phase_q == PhaseHalf) state_d = filt_q ? IDLE : DATA;
          else                      state_d = START;
        end
        DATA: begin
          if ((phase_q == PhaseLast) && (bit_idx_q == 3'd7)) state_d = STOP;
          else                                               state_d = DATA;
        end
        STOP: begin
          if (phase_q == PhaseLast) state_d = filt_q ? IDLE : WAIT_HIGH;
          else                      state_d = STOP;
        end
        WAIT_HIGH: begin
          if (filt_q) state_d = IDLE;
          else        state_d = WAIT_HIGH;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM output / datapath next values
  always_comb begin
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
    if (tick_s) begin
      case (state_q)
        IDLE: begin
          phase_d   = '0;
          bit_idx_d = 3'd0;
        end
        START: begin
          if (phase_q == PhaseHalf) phase_d = '0;
          else                      phase_d = phase_q + PhaseW'(1);
        end
        DATA: begin
          if (phase_q == PhaseLast) begin
            phase_d   = '0;
            shift_d   = {filt_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            phase_d = phase_q + PhaseW'(1);
          end
        end
        STOP: begin
          if (phase_q == PhaseLast) begin
            phase_d = '0;
            if (filt_q) begin
              data_d  = shift_q;
              ready_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            phase_d = phase_q + PhaseW'(1);
          end
        end
        WAIT_HIGH: phase_d = '0;
        default:   phase_d = '0;
      endcase
    end else begin
      phase_d = phase_q;
    end
  end

  // idle gap counter and end-of-packet qualification
  always_comb begin
    gap_d = gap_q;
    if (tick_s) begin
      if (!filt_q)                                           gap_d = '0;
      else if ((state_q == IDLE) && (gap_q != GapW'(GapMax))) gap_d = gap_q + GapW'(1);
      else                                                   gap_d = gap_q;
    end else begin
      gap_d = gap_q;
    end
    idle_d = (gap_d == GapW'(GapMax));
    eop_d  = idle_d & ~idle_q & got_byte_q;
    if (ready_d)    got_byte_d = 1'b1;
    else if (eop_d) got_byte_d = 1'b0;
    else            got_byte_d = got_byte_q;
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      ready_q    <= 1'b0;
      ferr_q     <= 1'b0;
      gap_q      <= '0;
      idle_q     <= 1'b0;
      eop_q      <= 1'b0;
      got_byte_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      ferr_q     <= ferr_d;
      gap_q      <= gap_d;
      idle_q     <= idle_d;
      eop_q      <= eop_d;
      got_byte_q <= got_byte_d;
    end
  end

  assign rx.RxD_data        = data_q;
  assign rx.RxD_data_ready  = ready_q;
  assign rx.RxD_frame_error = ferr_q;
  assign rx.RxD_idle        = idle_q;
  assign rx.RxD_endofpacket = eop_q;

endmodule

// File: tb/tb_async_receiver.sv
// Directed bench for async_receiver: 4 clks per tick, 32 clks per bit.
module tb_async_receiver;
  import async_receiver_pkg::*;

  localparam int unsigned CLK_HZ   = 3686400;
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned OVS      = 8;
  localparam int          BIT_CLKS = 32;
  localparam int          TICK_CLKS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  async_receiver_if rx_bus ();

  async_receiver #(
    .ClkFrequency(CLK_HZ),
    .Baud        (BAUD),
    .Oversampling(OVS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx_bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int ready_cnt = 0;
  int ferr_cnt  = 0;
  int eop_cnt   = 0;
  int both_cnt  = 0;
  logic [7:0] data_log [0:31];

  // pulse monitor: counts high cycles of each strobe and logs received bytes
  always @(negedge clk) begin
    if (rx_bus.RxD_data_ready) begin
      data_log[ready_cnt % 32] <= rx_bus.RxD_data;
      ready_cnt <= ready_cnt + 1;
    end
    if (rx_bus.RxD_frame_error) ferr_cnt <= ferr_cnt + 1;
    if (rx_bus.RxD_endofpacket) eop_cnt <= eop_cnt + 1;
    if (rx_bus.RxD_data_ready && rx_bus.RxD_frame_error) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx_bus.RxD = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold(b[i], BIT_CLKS);
    hold(stop_bit, BIT_CLKS);
  endtask

  initial begin
    rx_bus.RxD = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",  32'(rx_bus.RxD_data), 32'h00);
    check("rst_ready", 32'(rx_bus.RxD_data_ready), 32'd0);
    check("rst_ferr",  32'(rx_bus.RxD_frame_error), 32'd0);
    check("rst_idle",  32'(rx_bus.RxD_idle), 32'd0);
    check("rst_eop",   32'(rx_bus.RxD_endofpacket), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));

    rst_n = 1'b1;
    hold(1'b1, 17 * BIT_CLKS);
    check("boot_idle", 32'(rx_bus.RxD_idle), 32'd1);
    check("boot_no_eop", 32'(eop_cnt), 32'd0);

    // 0x55 then 0xA5
    send(8'h55, 1'b1);
    hold(1'b1, BIT_CLKS);
    check("f55_ready_cnt", 32'(ready_cnt), 32'd1);
    check("f55_data", 32'(rx_bus.RxD_data), 32'h55);
    send(8'hA5, 1'b1);
    hold(1'b1, BIT_CLKS);
    check("fA5_ready_cnt", 32'(ready_cnt), 32'd2);
    check("fA5_data", 32'(rx_bus.RxD_data), 32'hA5);
    check("fA5_log0", 32'(data_log[0]), 32'h55);
    check("fA5_ferr_cnt", 32'(ferr_cnt), 32'd0);

    // 3-tick low glitch
    hold(1'b0, 3 * TICK_CLKS);
    hold(1'b1, 2 * BIT_CLKS);
    check("glitch_ready_cnt", 32'(ready_cnt), 32'd2);
    check("glitch_ferr_cnt", 32'(ferr_cnt), 32'd0);
    check("glitch_state", 32'(dut.state_q), 32'(IDLE));
    check("glitch_data", 32'(rx_bus.RxD_data), 32'hA5);

    // 0x3C with bad stop bit, then 0x81
    send(8'h3C, 1'b0);
    hold(1'b1, 2 * BIT_CLKS);
    check("ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("ferr_ready_cnt", 32'(ready_cnt), 32'd2);
    check("ferr_data_kept", 32'(rx_bus.RxD_data), 32'hA5);
    check("ferr_state", 32'(dut.state_q), 32'(IDLE));
    send(8'h81, 1'b1);
    hold(1'b1, BIT_CLKS);
    check("f81_ready_cnt", 32'(ready_cnt), 32'd3);
    check("f81_data", 32'(rx_bus.RxD_data), 32'h81);

    // break: line held low for 20 bit times gives one frame error
    hold(1'b0, 20 * BIT_CLKS);
    hold(1'b1, 2 * BIT_CLKS);
    check("break_ferr_cnt", 32'(ferr_cnt), 32'd2);
    check("break_ready_cnt", 32'(ready_cnt), 32'd3);

    // back-to-back 0x00, 0xFF
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    hold(1'b1, BIT_CLKS);
    check("b2b_ready_cnt", 32'(ready_cnt), 32'd5);
    check("b2b_first", 32'(data_log[3]), 32'h00);
    check("b2b_second", 32'(data_log[4]), 32'hFF);
    check("b2b_ferr_cnt", 32'(ferr_cnt), 32'd2);

    // reset in the middle of bit 4 of 0xF0
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) hold(1'b0, BIT_CLKS);
    hold(1'b1, BIT_CLKS / 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_data", 32'(rx_bus.RxD_data), 32'h00);
    check("mid_rst_idle", 32'(rx_bus.RxD_idle), 32'd0);
    check("mid_rst_ready", 32'(rx_bus.RxD_data_ready), 32'd0);
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    hold(1'b1, 4);
    rst_n = 1'b1;
    hold(1'b1, 2 * BIT_CLKS);
    check("post_rst_ready_cnt", 32'(ready_cnt), 32'd5);
    check("post_rst_ferr_cnt", 32'(ferr_cnt), 32'd2);
    check("post_rst_data", 32'(rx_bus.RxD_data), 32'h00);
    send(8'h12, 1'b1);
    hold(1'b1, BIT_CLKS);
    check("f12_ready_cnt", 32'(ready_cnt), 32'd6);
    check("f12_data", 32'(rx_bus.RxD_data), 32'h12);
    check("pre_eop_cnt", 32'(eop_cnt), 32'd0);

    // 0x7E then long idle: one end-of-packet only
    send(8'h7E, 1'b1);
    check("f7E_idle_low", 32'(rx_bus.RxD_idle), 32'd0);
    hold(1'b1, 17 * BIT_CLKS);
    check("f7E_data", 32'(rx_bus.RxD_data), 32'h7E);
    check("eop_idle", 32'(rx_bus.RxD_idle), 32'd1);
    check("eop_cnt", 32'(eop_cnt), 32'd1);
    hold(1'b1, 16 * BIT_CLKS);
    check("eop_no_second", 32'(eop_cnt), 32'd1);
    check("eop_idle_stays", 32'(rx_bus.RxD_idle), 32'd1);
    check("ready_ferr_exclusive", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/async_receiver.md
ASYNC_RECEIVER -- requirements
Module: async_receiver

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter ClkFrequency, default 25000000, is the clk frequency in Hz.
REQ-003 Parameter Baud, default 115200, is the line bit rate.
REQ-004 Parameter Oversampling, default 8, is the number of sample ticks per bit; it SHALL be a power of two, at least 4.
REQ-005 Port clk, input, 1 bit, is the system clock; all logic is clocked on its rising edge.
REQ-006 Port rst_n, input, 1 bit, is the asynchronous active-low reset.
REQ-007 Port RxD, input, 1 bit, is the asynchronous serial line; it idles high and carries 8N1, LSB first.
REQ-008 Port RxD_data, output, 8 bits, holds the last correctly framed byte.
REQ-009 Port RxD_data_ready, output, 1 bit, is a one-clk pulse: RxD_data has just been updated.
REQ-010 Port RxD_frame_error, output, 1 bit, is a one-clk pulse: the stop bit was sampled low.
REQ-011 Port RxD_idle, output, 1 bit, is high while the line has been idle for at least 16 bit times.
REQ-012 Port RxD_endofpacket, output, 1 bit, is a one-clk pulse when RxD_idle rises after at least one byte was received.

Function
REQ-013 RxD SHALL pass through a 2-FF synchronizer.
  - The synchronizer output then feeds a 2-of-3 majority filter sampled on OversampleTick.
  - The filtered level is the only line value used.
REQ-014 OversampleTick SHALL pulse one clk cycle at Baud*Oversampling Hz. It runs continuously, not only while receiving.
REQ-015 The FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-016 IDLE -> START on the first tick where the filtered line is 0; this clears the 0..Oversampling-1 phase counter.
REQ-017 START SHALL check the line at phase Oversampling/2-1:
  - line 0: go to DATA, phase counter restarts;
  - line 1: glitch, return to IDLE with no output pulse.
REQ-018 DATA SHALL sample once per bit at the bit centre, when the phase counter wraps. Samples shift into an 8-bit register LSB first, and a 3-bit index counts bits 0..7.
REQ-019 After bit 7 the FSM SHALL enter STOP and sample the stop bit at its centre:
  - stop = 1: load RxD_data from the shift register, pulse RxD_data_ready, go to IDLE;
  - stop = 0: pulse RxD_frame_error, leave RxD_data unchanged, go to WAIT_HIGH.
REQ-020 WAIT_HIGH -> IDLE on the first tick where the filtered line is 1. A break (line held low) SHALL produce exactly one frame_error pulse.
REQ-021 RxD_data_ready and RxD_frame_error SHALL be mutually exclusive. Each asserts once per frame, between 9.5 and 9.5+3/Oversampling bit times after the start edge, plus 2 synchronizer clks.
REQ-022 A new start bit arriving immediately after a valid stop-bit centre SHALL be detected. Back-to-back frames with zero idle gap are received without loss.
REQ-023 The gap counter SHALL:
  - count ticks while in IDLE with the line high;
  - clear on any low sample;
  - saturate at 16*Oversampling, asserting RxD_idle.
REQ-024 RxD_endofpacket SHALL pulse on the RxD_idle rising edge only if a byte completed since the previous pulse.
REQ-025 Generation SHALL fail if ClkFrequency < Baud*Oversampling.

Reset
REQ-026 While rst_n = 0, all outputs SHALL immediately take their reset values:
  - RxD_data = 8'h00;
  - RxD_data_ready = 0, RxD_frame_error = 0, RxD_endofpacket = 0;
  - RxD_idle = 0.
REQ-027 While rst_n = 0, internal state SHALL be forced: synchronizer and filter to 1, FSM to IDLE, all counters to 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial byte without any pulse. After release, the next full frame is received correctly.

Structure
REQ-029 The FSM state encoding and the default ClkFrequency and Baud SHALL live in the shared uart package with the transmitter constants.
REQ-030 The tick SHALL come from the existing baudrate_gen sub-module:
  - instantiated with Baud*Oversampling;
  - enable tied to 1.
  No other sub-module is used.

Verification
REQ-031 Bench SHALL run with Oversampling = 8 and check at least these directed scenarios:
  - Frame 0x55, then 0xA5 -> two ready pulses; RxD_data = 0x55 then 0xA5; no frame_error.
  - Low glitch of 3 OversampleTicks on an idle line -> no pulse; FSM back in IDLE; RxD_data unchanged.
  - Frame 0x3C with stop bit driven 0, then line high -> exactly one frame_error pulse; RxD_data keeps its previous value; next frame 0x81 received.
  - Back-to-back 0x00, 0xFF with zero gap -> two ready pulses, correct data.
  - rst_n pulsed low during bit 4 of 0xF0 -> no pulse; outputs at reset values; the following 0x12 is received.
  - One byte 0x7E, then line high for 16 bit times -> RxD_idle rises and exactly one endofpacket pulse; a further 16 bit times idle -> no second pulse.
